code_lock_core: RTL and testbench

//  Parametrised successor to the single-shot 4-bit lock: multi-digit code entry,

---
 rtl/code_lock_core_pkg.sv | 18 +
 rtl/code_lock_core_timer.sv | 29 ++
 rtl/code_lock_core.sv | 197 +++++++++++++++++++
 tb/tb_code_lock_core.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/code_lock_core_pkg.sv
// Shared definitions for the code lock core.
// State codes are also decoded by the display logic.
package code_lock_core_pkg;

  localparam logic [2:0] ST_LOCKED  = 3'd0;
  localparam logic [2:0] ST_CHECK   = 3'd1;
  localparam logic [2:0] ST_OPEN    = 3'd2;
  localparam logic [2:0] ST_PROG    = 3'd3;
  localparam logic [2:0] ST_LOCKOUT = 3'd4;

  function automatic int max_int(
    input int a,
    input int b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/code_lock_core_timer.sv
// Loadable down-counter shared by lockout and auto-relock.
// Saturates at zero; load has priority over decrement.
module code_lock_core_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] value;

  // count down, never wrapping below zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (dec && (value != '0)) begin
      value <= value - W'(1);
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/code_lock_core.sv
// Multi-digit code lock: entry, check, reprogram,
// retry lockout and optional auto-relock.
module code_lock_core
  import code_lock_core_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int DIG_W    = 4,
  parameter logic [DIGITS*DIG_W-1:0] DEFAULT_PWD = 16'h1234,
  parameter int MAX_TRY  = 3,
  parameter int LOCK_CYC = 1000,
  parameter int OPEN_CYC = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DIG_W-1:0]             digit_in,
  input  logic                         enter_trig,
  input  logic                         init_trig,
  output logic                         unlocked,
  output logic                         alarm,
  output logic                         result_vld,
  output logic                         result_ok,
  output logic [$clog2(DIGITS+1)-1:0]  entry_cnt,
  output logic [$clog2(MAX_TRY+1)-1:0] fail_cnt,
  output logic [2:0]                   state_o,
  output logic [DIGITS*DIG_W-1:0]      entry_buf
);

  localparam int BW = DIGITS * DIG_W;
  localparam int CW = $clog2(DIGITS + 1);
  localparam int FW = $clog2(MAX_TRY + 1);
  localparam int TW = $clog2(max_int(LOCK_CYC, OPEN_CYC) + 1);
  localparam int OPEN_LD = (OPEN_CYC > 0) ? OPEN_CYC - 1 : 0;

  localparam logic [TW-1:0] LOCK_VAL = TW'(LOCK_CYC - 1);
  localparam logic [TW-1:0] OPEN_VAL = TW'(OPEN_LD);
  localparam logic [CW-1:0] LAST     = CW'(DIGITS - 1);
  localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_TRY);
  localparam logic          AUTO     = (OPEN_CYC != 0);

  logic [2:0]    state;
  logic [2:0]    state_d;
  logic [BW-1:0] pwd;
  logic [BW-1:0] pwd_d;
  logic [BW-1:0] buf_d;
  logic [CW-1:0] cnt_d;
  logic [FW-1:0] fail_d;
  logic          vld_d;
  logic          ok_d;
  logic          tmr_load;
  logic          tmr_dec;
  logic [TW-1:0] tmr_val;
  logic          tmr_zero;
  logic          ent;
  logic          ini;
  logic [BW-1:0] shifted;
  logic [CW-1:0] cnt_inc;
  logic [FW-1:0] fail_inc;

  // init_trig wins when both pulses coincide
  assign ini = init_trig;
  assign ent = enter_trig & ~init_trig;

  assign shifted  = (entry_buf << DIG_W) | BW'(digit_in);
  assign cnt_inc  = entry_cnt + CW'(1);
  assign fail_inc = fail_cnt + FW'(1);

  code_lock_core_timer #(
    .W (TW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // next-state and datapath decisions
  always_comb begin
    state_d  = state;
    pwd_d    = pwd;
    buf_d    = entry_buf;
    cnt_d    = entry_cnt;
    fail_d   = fail_cnt;
    vld_d    = 1'b0;
    ok_d     = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = LOCK_VAL;
    unique case (state)
      ST_LOCKED: begin
        if (ini) begin
          buf_d = '0;
          cnt_d = '0;
        end else if (ent) begin
          buf_d = shifted;
          cnt_d = cnt_inc;
          if (entry_cnt == LAST) begin
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        buf_d = '0;
        cnt_d = '0;
        vld_d = 1'b1;
        if (entry_buf == pwd) begin
          ok_d     = 1'b1;
          fail_d   = '0;
          state_d  = ST_OPEN;
          tmr_load = AUTO;
          tmr_val  = OPEN_VAL;
        end else begin
          fail_d = fail_inc;
          if (fail_inc == FAIL_MAX) begin
            state_d  = ST_LOCKOUT;
            tmr_load = 1'b1;
            tmr_val  = LOCK_VAL;
          end else begin
            state_d = ST_LOCKED;
          end
        end
      end
      ST_OPEN: begin
        tmr_dec = AUTO;
        if (ini) begin
          state_d = ST_PROG;
          buf_d   = '0;
          cnt_d   = '0;
        end else if (ent) begin
          state_d = ST_LOCKED;
        end else if (AUTO && tmr_zero) begin
          state_d = ST_LOCKED;
        end
      end
      ST_PROG: begin
        if (ini) begin
          buf_d    = '0;
          cnt_d    = '0;
          state_d  = ST_OPEN;
          tmr_load = AUTO;
          tmr_val  = OPEN_VAL;
        end else if (ent) begin
          if (entry_cnt == LAST) begin
            pwd_d   = shifted;
            vld_d   = 1'b1;
            ok_d    = 1'b1;
            buf_d   = '0;
            cnt_d   = '0;
            state_d = ST_LOCKED;
          end else begin
            buf_d = shifted;
            cnt_d = cnt_inc;
          end
        end
      end
      ST_LOCKOUT: begin
        tmr_dec = 1'b1;
        if (tmr_zero) begin
          state_d = ST_LOCKED;
          fail_d  = '0;
        end
      end
      default: begin
        state_d = ST_LOCKED;
      end
    endcase
  end

  // register state and every output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_LOCKED;
      pwd        <= DEFAULT_PWD;
      entry_buf  <= '0;
      entry_cnt  <= '0;
      fail_cnt   <= '0;
      result_vld <= 1'b0;
      result_ok  <= 1'b0;
      unlocked   <= 1'b0;
      alarm      <= 1'b0;
    end else begin
      state      <= state_d;
      pwd        <= pwd_d;
      entry_buf  <= buf_d;
      entry_cnt  <= cnt_d;
      fail_cnt   <= fail_d;
      result_vld <= vld_d;
      result_ok  <= ok_d;
      unlocked   <= (state_d == ST_OPEN) || (state_d == ST_PROG);
      alarm      <= (state_d == ST_LOCKOUT);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_code_lock_core.sv
// Scoreboard bench for code_lock_core.
// Results are queued at stimulus time, popped on result_vld.
module tb_code_lock_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  digit_in;
  logic        enter_trig;
  logic        init_trig;
  logic        unlocked;
  logic        alarm;
  logic        result_vld;
  logic        result_ok;
  logic [2:0]  entry_cnt;
  logic [1:0]  fail_cnt;
  logic [2:0]  state_o;
  logic [15:0] entry_buf;

  typedef struct {
    bit ok;
    int cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   last_res_cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   mark;

  code_lock_core #(
    .DIGITS      (4),
    .DIG_W       (4),
    .DEFAULT_PWD (16'h1234),
    .MAX_TRY     (3),
    .LOCK_CYC    (100),
    .OPEN_CYC    (50)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digit_in   (digit_in),
    .enter_trig (enter_trig),
    .init_trig  (init_trig),
    .unlocked   (unlocked),
    .alarm      (alarm),
    .result_vld (result_vld),
    .result_ok  (result_ok),
    .entry_cnt  (entry_cnt),
    .fail_cnt   (fail_cnt),
    .state_o    (state_o),
    .entry_buf  (entry_buf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && result_vld === 1'b1) begin
      if (q.size() == 0) begin
        chk("vld_spurious", 1, 0);
      end else begin
        mon_e = q.pop_front();
        chk("res_ok", result_ok, mon_e.ok);
        chk("res_lat", cyc, mon_e.cyc);
        last_res_cyc = cyc;
      end
    end
  end

  task automatic press(
    input logic [3:0] d,
    input bit         en,
    input bit         in,
    input bit         push,
    input bit         ok,
    input int         lat
  );
    @(negedge clk);
    if (push) q.push_back('{ok: ok, cyc: cyc + lat});
    digit_in   = d;
    enter_trig = en;
    init_trig  = in;
    @(negedge clk);
    enter_trig = 1'b0;
    init_trig  = 1'b0;
  endtask

  task automatic code(
    input logic [15:0] c,
    input bit          push,
    input bit          ok,
    input int          lat
  );
    logic [15:0] v;
    v = c;
    for (int i = 0; i < 4; i++) begin
      press(v[15-4*i -: 4], 1'b1, 1'b0,
            push && (i == 3), ok, lat);
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(tag, q.size(), 0);
  endtask

  task automatic relock();
    press(4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    #1;
    chk("relock_st", state_o, 0);
    chk("relock_unl", unlocked, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    digit_in   = '0;
    enter_trig = 1'b0;
    init_trig  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_unl", unlocked, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_vld", result_vld, 0);
    chk("rst_ok", result_ok, 0);
    chk("rst_cnt", entry_cnt, 0);
    chk("rst_fail", fail_cnt, 0);
    chk("rst_st", state_o, 0);
    chk("rst_buf", entry_buf, 0);
    rst_n = 1'b1;

    // 1: default code opens
    code(16'h1234, 1'b1, 1'b1, 2);
    drain("t1_drain");
    chk("t1_unl", unlocked, 1);
    chk("t1_fail", fail_cnt, 0);
    chk("t1_st", state_o, 2);
    chk("t1_cnt", entry_cnt, 0);
    relock();

    // 2: three misses, lockout for 100 cycles
    for (int k = 1; k <= 3; k++) begin
      code(16'h1235, 1'b1, 1'b0, 2);
      drain("t2_drain");
      chk("t2_fail", fail_cnt, k);
    end
    mark = last_res_cyc;
    chk("t2_alarm", alarm, 1);
    chk("t2_st", state_o, 4);
    chk("t2_unl", unlocked, 0);
    code(16'h1234, 1'b0, 1'b0, 0);
    press(4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    #1;
    chk("t2_ign_cnt", entry_cnt, 0);
    chk("t2_ign_st", state_o, 4);
    while (cyc < mark + 99) @(negedge clk);
    #1;
    chk("t2_alarm_end", alarm, 1);
    @(negedge clk);
    #1;
    chk("t2_alarm_off", alarm, 0);
    chk("t2_fail_clr", fail_cnt, 0);
    chk("t2_st_back", state_o, 0);

    // 3: reprogram to 9876
    code(16'h1234, 1'b1, 1'b1, 2);
    drain("t3_drain_a");
    press(4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    #1;
    chk("t3_prog_st", state_o, 3);
    chk("t3_prog_unl", unlocked, 1);
    code(16'h9876, 1'b1, 1'b1, 1);
    drain("t3_drain_b");
    chk("t3_st", state_o, 0);
    chk("t3_unl", unlocked, 0);
    code(16'h1234, 1'b1, 1'b0, 2);
    drain("t3_drain_c");
    chk("t3_old_fail", fail_cnt, 1);
    code(16'h9876, 1'b1, 1'b1, 2);
    drain("t3_drain_d");
    chk("t3_new_unl", unlocked, 1);
    chk("t3_fail_clr", fail_cnt, 0);
    relock();

    // 4: auto-relock after 50 cycles, PROG abort
    code(16'h9876, 1'b1, 1'b1, 2);
    drain("t4_drain_a");
    mark = last_res_cyc;
    while (cyc < mark + 49) @(negedge clk);
    #1;
    chk("t4_open_end", unlocked, 1);
    @(negedge clk);
    #1;
    chk("t4_relocked", unlocked, 0);
    chk("t4_st", state_o, 0);
    code(16'h9876, 1'b1, 1'b1, 2);
    drain("t4_drain_b");
    press(4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    press(4'h9, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    #1;
    chk("t4_prog_cnt", entry_cnt, 1);
    press(4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    #1;
    chk("t4_abort_st", state_o, 2);
    chk("t4_abort_cnt", entry_cnt, 0);
    relock();
    code(16'h9876, 1'b1, 1'b1, 2);
    drain("t4_drain_c");
    relock();

    // 5: partial entry cleared, simultaneous triggers
    press(4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    press(4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    #1;
    chk("t5_cnt", entry_cnt, 2);
    chk("t5_buf", entry_buf, 16'h0012);
    press(4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    #1;
    chk("t5_clr_cnt", entry_cnt, 0);
    chk("t5_clr_buf", entry_buf, 0);
    press(4'h3, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    press(4'h7, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    #1;
    chk("t5_both_cnt", entry_cnt, 0);
    chk("t5_both_buf", entry_buf, 0);
    chk("t5_both_st", state_o, 0);
    code(16'h9876, 1'b1, 1'b1, 2);
    drain("t5_drain");
    chk("t5_unl", unlocked, 1);

    // 6: reset mid-programming restores default
    press(4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    press(4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    press(4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_unl", unlocked, 0);
    chk("t6_cnt", entry_cnt, 0);
    chk("t6_buf", entry_buf, 0);
    chk("t6_st", state_o, 0);
    chk("t6_vld", result_vld, 0);
    @(negedge clk);
    rst_n = 1'b1;
    code(16'h9876, 1'b1, 1'b0, 2);
    drain("t6_drain_a");
    code(16'h1234, 1'b1, 1'b1, 2);
    drain("t6_drain_b");
    chk("t6_def_unl", unlocked, 1);
    chk("t6_fail_clr", fail_cnt, 0);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
